// File: rtl/lsu_rmw.sv
// rtl/lsu_rmw.sv - load/store unit with read-modify-write for sub-word stores
//
// Purpose: turns byte/halfword/word loads and stores (RISC-V funct3 encoding,
// little-endian) into word accesses on a word-wide data memory. Sub-word
// stores read the word, merge the new lane and write it back; loads are
// sign- or zero-extended. Misaligned or illegal requests complete with err
// set and never touch memory.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   req, we, funct3,    request handshake: captured in IDLE when req=1
//   addr, wdata
//   busy, done, err     status: busy while not IDLE, done one-cycle pulse,
//                       err qualified by done
//   rdata               extended load result, held until the next load
//   mem_we, mem_a,      data memory write enable, word address, write data
//   mem_wd
//   mem_rd              data memory read data (combinational on mem_a)
module lsu_rmw (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    // pend_q marks the IDLE cycle after capture, in which the captured
    // request is decoded; busy stays low during it.
    logic        pend_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [31:0] wword_q;
    logic        err_q;

    logic        illegal, misaligned, bad;
    logic        word_store;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    logic [31:0] merged;

    always_comb begin
        illegal    = (f3_q == 3'b011) || (f3_q == 3'b110) || (f3_q == 3'b111) ||
                     (we_q && f3_q[2]);
        misaligned = ((f3_q == 3'b001) && addr_q[0]) ||
                     ((f3_q == 3'b010) && (addr_q[1:0] != 2'b00));
        bad        = illegal || misaligned;
        word_store = we_q && (f3_q == 3'b010);
    end

    // Lane selection from the word read back from memory.
    always_comb begin
        case (addr_q[1:0])
            2'd0:    rd_byte = mem_rd[7:0];
            2'd1:    rd_byte = mem_rd[15:8];
            2'd2:    rd_byte = mem_rd[23:16];
            default: rd_byte = mem_rd[31:24];
        endcase
        rd_half = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
        case (f3_q)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_val = {24'd0, rd_byte};
            3'b101:  load_val = {16'd0, rd_half};
            default: load_val = mem_rd;
        endcase
    end

    // Sub-word store merge: replace only the addressed lane(s).
    always_comb begin
        merged = mem_rd;
        if (f3_q == 3'b000) begin
            case (addr_q[1:0])
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    if (bad)             state_d = DONE;
                    else if (word_store) state_d = WRITE;
                    else                 state_d = READ;
                end
            end
            READ:    state_d = we_q ? WRITE : DONE;
            WRITE:   state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            wword_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (pend_q) begin
                    pend_q <= 1'b0;
                    err_q  <= bad;
                    if (!bad && word_store) wword_q <= wdata_q;
                end else if (req) begin
                    pend_q  <= 1'b1;
                    we_q    <= we;
                    f3_q    <= funct3;
                    addr_q  <= addr;
                    wdata_q <= wdata;
                end
            end
            if (state_q == READ) begin
                if (we_q) wword_q <= merged;
                else      rdata_q <= load_val;
            end
        end
    end

    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE);
        err    = done && err_q;
        rdata  = rdata_q;
        // Gating with reset keeps an aborted WRITE from landing in memory.
        mem_we = (state_q == WRITE) && !reset;
        mem_a  = ((state_q == READ) || (state_q == WRITE)) ? {addr_q[31:2], 2'b00} : 32'd0;
        mem_wd = (state_q == WRITE) ? wword_q : 32'd0;
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// tb/tb_lsu_rmw.sv - directed self-checking testbench for lsu_rmw
module tb_lsu_rmw;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy, done, err, mem_we;
    logic [31:0] rdata, mem_a, mem_wd, mem_rd;
    logic        mem_clr = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] dmem [16];

    always #5 clk = ~clk;

    lsu_rmw dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_rd(mem_rd)
    );

    assign mem_rd = dmem[mem_a[5:2]];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) dmem[i] <= 32'd0;
        end else if (mem_we) begin
            dmem[mem_a[5:2]] <= mem_wd;
        end
    end

    // Issue one request, scramble the inputs after acceptance, then watch
    // until done (bounded) collecting latency and write activity.
    task automatic run(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output logic e,
                       output int nwe, output logic [31:0] wa, output logic [31:0] wd,
                       output logic b0, output logic bd);
        @(negedge clk);
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req = 1'b0; we = ~w; funct3 = ~f3; addr = ~a; wdata = ~d;
        lat = -1; e = 1'bx; nwe = 0; wa = 32'd0; wd = 32'd0; b0 = 1'bx; bd = 1'bx;
        for (int k = 0; k < 10 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 0) b0 = busy;
            if (mem_we) begin nwe++; wa = mem_a; wd = mem_wd; end
            if (done) begin lat = k; e = err; bd = busy; end
            if (k > 0) @(posedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; mem_clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0; mem_clr = 1'b0;
        @(negedge clk);
        vectors++;
        if ({busy, done, err, mem_we} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_status got %b exp 0000", {busy, done, err, mem_we});
        end
        vectors++;
        if ({rdata, mem_a, mem_wd} !== 96'd0) begin
            miscompares++; $display("FAIL reset_data got %h %h %h exp 0", rdata, mem_a, mem_wd);
        end
    endtask

    task automatic test_word_store;
        int lat, nwe; logic e, b0, bd; logic [31:0] wa, wd;
        run(1'b1, 3'b010, 32'h4, 32'hAABBCCDD, lat, e, nwe, wa, wd, b0, bd);
        vectors++;
        if (lat !== 2 || e !== 1'b0) begin
            miscompares++; $display("FAIL sw_latency got lat=%0d err=%b exp lat=2 err=0", lat, e);
        end
        vectors++;
        if (nwe !== 1 || wa !== 32'h4 || wd !== 32'hAABBCCDD) begin
            miscompares++; $display("FAIL sw_write got n=%0d a=%h d=%h exp n=1 a=4 d=aabbccdd", nwe, wa, wd);
        end
        vectors++;
        if (b0 !== 1'b0 || bd !== 1'b1) begin
            miscompares++; $display("FAIL sw_busy got first=%b done=%b exp 0 1", b0, bd);
        end
        @(negedge clk);
        vectors++;
        if (dmem[1] !== 32'hAABBCCDD) begin
            miscompares++; $display("FAIL sw_mem got %h exp aabbccdd", dmem[1]);
        end
    endtask

    task automatic test_loads;
        logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        logic [31:0] as  [5] = '{32'h5, 32'h5, 32'h6, 32'h6, 32'h4};
        logic [31:0] exs [5] = '{32'hFFFFFFCC, 32'h000000CC, 32'hFFFFAABB, 32'h0000AABB, 32'hAABBCCDD};
        int lat, nwe; logic e, b0, bd; logic [31:0] wa, wd;
        for (int i = 0; i < 5; i++) begin
            run(1'b0, f3s[i], as[i], 32'h0, lat, e, nwe, wa, wd, b0, bd);
            vectors++;
            if (rdata !== exs[i]) begin
                miscompares++; $display("FAIL load%0d_rdata got %h exp %h", i, rdata, exs[i]);
            end
            vectors++;
            if (lat !== 2 || e !== 1'b0 || nwe !== 0) begin
                miscompares++; $display("FAIL load%0d_timing got lat=%0d err=%b nwe=%0d exp 2 0 0", i, lat, e, nwe);
            end
        end
    endtask

    task automatic test_subword_store;
        int lat, nwe; logic e, b0, bd; logic [31:0] wa, wd;
        run(1'b1, 3'b000, 32'h7, 32'h00000011, lat, e, nwe, wa, wd, b0, bd);
        vectors++;
        if (lat !== 3 || e !== 1'b0 || nwe !== 1 || wa !== 32'h4 || wd !== 32'h11BBCCDD) begin
            miscompares++; $display("FAIL sb_write got lat=%0d err=%b n=%0d a=%h d=%h exp 3 0 1 4 11bbccdd", lat, e, nwe, wa, wd);
        end
        run(1'b0, 3'b010, 32'h4, 32'h0, lat, e, nwe, wa, wd, b0, bd);
        vectors++;
        if (rdata !== 32'h11BBCCDD) begin
            miscompares++; $display("FAIL sb_readback got %h exp 11bbccdd", rdata);
        end
        run(1'b1, 3'b010, 32'h8, 32'h11223344, lat, e, nwe, wa, wd, b0, bd);
        run(1'b1, 3'b001, 32'h8, 32'h00001234, lat, e, nwe, wa, wd, b0, bd);
        vectors++;
        if (lat !== 3 || nwe !== 1 || wa !== 32'h8 || wd !== 32'h11221234) begin
            miscompares++; $display("FAIL sh_write got lat=%0d n=%0d a=%h d=%h exp 3 1 8 11221234", lat, nwe, wa, wd);
        end
        run(1'b0, 3'b010, 32'h8, 32'h0, lat, e, nwe, wa, wd, b0, bd);
        vectors++;
        if (rdata !== 32'h11221234) begin
            miscompares++; $display("FAIL sh_readback got %h exp 11221234", rdata);
        end
    endtask

    task automatic test_errors;
        logic        ws  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [4] = '{3'b001, 3'b010, 3'b100, 3'b011};
        logic [31:0] as  [4] = '{32'h5, 32'h6, 32'h4, 32'h4};
        int lat, nwe; logic e, b0, bd; logic [31:0] wa, wd;
        for (int i = 0; i < 4; i++) begin
            run(ws[i], f3s[i], as[i], 32'hDEADBEEF, lat, e, nwe, wa, wd, b0, bd);
            vectors++;
            if (lat !== 1 || e !== 1'b1 || nwe !== 0) begin
                miscompares++; $display("FAIL err%0d got lat=%0d err=%b nwe=%0d exp 1 1 0", i, lat, e, nwe);
            end
            vectors++;
            if (rdata !== 32'h11221234) begin
                miscompares++; $display("FAIL err%0d_rdata got %h exp 11221234", i, rdata);
            end
        end
        vectors++;
        if (dmem[1] !== 32'h11BBCCDD || dmem[2] !== 32'h11221234) begin
            miscompares++; $display("FAIL err_mem got %h %h exp 11bbccdd 11221234", dmem[1], dmem[2]);
        end
    endtask

    task automatic test_busy_ignore;
        int ndone = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h4; wdata = 32'h77;
        @(posedge clk);
        #1 req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy && mem_a == 32'h4 && !mem_we && ndone == 0) begin
                req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h8; wdata = 32'hDEADBEEF;
            end else begin
                req = 1'b0;
            end
            if (done) ndone++;
        end
        vectors++;
        if (ndone !== 1) begin
            miscompares++; $display("FAIL busy_done_count got %0d exp 1", ndone);
        end
        vectors++;
        if (dmem[2] !== 32'h11221234 || dmem[1] !== 32'h11BBCC77) begin
            miscompares++; $display("FAIL busy_mem got %h %h exp 11221234 11bbcc77", dmem[2], dmem[1]);
        end
    endtask

    task automatic test_reset_mid_write;
        int ndone = 0;
        logic hit = 1'b0;
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'hC; wdata = 32'h55;
        @(posedge clk);
        #1 req = 1'b0;
        for (int k = 0; k < 5 && !hit; k++) begin
            @(negedge clk);
            if (mem_we) begin
                hit = 1'b1;
                reset = 1'b1;
                #1;
                vectors++;
                if (mem_we !== 1'b0 || busy !== 1'b0) begin
                    miscompares++; $display("FAIL rst_write got we=%b busy=%b exp 0 0", mem_we, busy);
                end
            end
        end
        vectors++;
        if (!hit) begin
            miscompares++; $display("FAIL rst_write_reached got 0 exp 1");
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        vectors++;
        if (ndone !== 0 || dmem[3] !== 32'd0) begin
            miscompares++; $display("FAIL rst_abort got done=%0d mem=%h exp 0 0", ndone, dmem[3]);
        end
    endtask

    initial begin
        test_reset;
        test_word_store;
        test_loads;
        test_subword_store;
        test_errors;
        test_busy_ignore;
        test_reset_mid_write;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
